// File: rtl/axicb_pkg.sv
// Shared definitions for the crossbar register slice: slice-type codes and the
// skid-stage state encoding with its occupancy decode.
package axicb_pkg;

  localparam int AXICB_SLICE_BYPASS = 0;
  localparam int AXICB_SLICE_FWD    = 1;
  localparam int AXICB_SLICE_FULL   = 2;
  localparam int AXICB_SLICE_BWD    = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } axicb_full_state_e;

  function automatic logic [1:0] axicb_state_count(input axicb_full_state_e st);
    case (st)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/axicb_reg_slice_stage.sv
// One valid/ready pipeline stage: forward-registered, full skid or
// backward-registered, reporting how many beats it currently holds.
module axicb_reg_slice_stage
  import axicb_pkg::*;
#(
  parameter int DATA_BUS_W = 8,
  parameter int MODE       = AXICB_SLICE_FULL
)(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_BUS_W-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_BUS_W-1:0] o_data,
  output logic [1:0]            o_count
);

  generate
    if (MODE == AXICB_SLICE_FWD) begin : g_fwd
      logic                  r_valid;
      logic [DATA_BUS_W-1:0] r_data;
      logic                  w_in_ready;

      assign w_in_ready = ~r_valid | o_ready;

      // Data/valid register, reloaded whenever the slot is free or draining
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_valid <= 1'b0;
          r_data  <= {DATA_BUS_W{1'b0}};
        end else if (srst) begin
          r_valid <= 1'b0;
          r_data  <= {DATA_BUS_W{1'b0}};
        end else if (w_in_ready) begin
          r_valid <= i_valid;
          if (i_valid) begin
            r_data <= i_data;
          end
        end
      end

      assign i_ready = w_in_ready;
      assign o_valid = r_valid;
      assign o_data  = r_data;
      assign o_count = {1'b0, r_valid};

    end else if (MODE == AXICB_SLICE_FULL) begin : g_full
      axicb_full_state_e     r_state;
      axicb_full_state_e     w_next;
      logic                  r_in_ready;
      logic [DATA_BUS_W-1:0] r_main;
      logic [DATA_BUS_W-1:0] r_skid;
      logic                  w_in_fire;
      logic                  w_out_fire;

      assign w_in_fire  = i_valid & r_in_ready;
      assign w_out_fire = (r_state != ST_EMPTY) & o_ready;

      // State register; ready is precomputed from the next state so it is a flop
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b0;
        end else if (srst) begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b0;
        end else begin
          r_state    <= w_next;
          r_in_ready <= (w_next != ST_FULL);
        end
      end

      // Next-state decode
      always_comb begin
        w_next = r_state;
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) w_next = ST_BUSY;
            else           w_next = ST_EMPTY;
          end
          ST_BUSY: begin
            if (w_in_fire && !w_out_fire)      w_next = ST_FULL;
            else if (!w_in_fire && w_out_fire) w_next = ST_EMPTY;
            else                               w_next = ST_BUSY;
          end
          ST_FULL: begin
            if (w_out_fire) w_next = ST_BUSY;
            else            w_next = ST_FULL;
          end
          default: w_next = ST_EMPTY;
        endcase
      end

      // Main/skid payload registers
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_main <= {DATA_BUS_W{1'b0}};
          r_skid <= {DATA_BUS_W{1'b0}};
        end else if (srst) begin
          r_main <= {DATA_BUS_W{1'b0}};
          r_skid <= {DATA_BUS_W{1'b0}};
        end else begin
          case (r_state)
            ST_EMPTY: if (w_in_fire) r_main <= i_data;
            ST_BUSY: begin
              if (w_in_fire && w_out_fire) r_main <= i_data;
              else if (w_in_fire)          r_skid <= i_data;
            end
            ST_FULL:  if (w_out_fire) r_main <= r_skid;
            default: ;
          endcase
        end
      end

      // Output decode, all from registers
      always_comb begin
        o_valid = (r_state != ST_EMPTY);
        o_data  = r_main;
        i_ready = r_in_ready;
        o_count = axicb_state_count(r_state);
      end

    end else if (MODE == AXICB_SLICE_BWD) begin : g_bwd
      logic                  r_skid_valid;
      logic                  r_in_ready;
      logic [DATA_BUS_W-1:0] r_skid;
      logic                  w_capture;
      logic                  w_skid_valid_nxt;

      // Ready is low out of reset, so gating with it keeps pass-through quiet then
      assign w_capture = ~r_skid_valid & i_valid & r_in_ready & ~o_ready;

      // Skid occupancy for the next cycle
      always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        if (r_skid_valid) begin
          w_skid_valid_nxt = ~o_ready;
        end else begin
          w_skid_valid_nxt = w_capture;
        end
      end

      // Skid register and registered ready
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b0;
          r_skid       <= {DATA_BUS_W{1'b0}};
        end else if (srst) begin
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b0;
          r_skid       <= {DATA_BUS_W{1'b0}};
        end else begin
          r_skid_valid <= w_skid_valid_nxt;
          r_in_ready   <= ~w_skid_valid_nxt;
          if (w_capture) begin
            r_skid <= i_data;
          end
        end
      end

      assign i_ready = r_in_ready;
      assign o_valid = r_skid_valid | (i_valid & r_in_ready);
      assign o_data  = r_skid_valid ? r_skid : (r_in_ready ? i_data : {DATA_BUS_W{1'b0}});
      assign o_count = {1'b0, r_skid_valid};

    end else begin : g_pass
      logic w_unused_clk;
      assign w_unused_clk = aclk ^ aresetn ^ srst;
      assign i_ready = o_ready;
      assign o_valid = i_valid;
      assign o_data  = i_data;
      assign o_count = 2'd0;
    end
  endgenerate

endmodule

// File: rtl/axicb_reg_slice.sv
// Crossbar channel register slice: NB_PIPELINE chained stages of one slice
// type, with the summed stage occupancy exported on o_level.
module axicb_reg_slice
  import axicb_pkg::*;
#(
  parameter  int DATA_BUS_W  = 8,
  parameter  int NB_PIPELINE = 1,
  parameter  int MODE        = AXICB_SLICE_FULL,
  localparam int LEVEL_W     = (NB_PIPELINE < 1) ? 1 : $clog2(2 * NB_PIPELINE + 1)
)(
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_BUS_W-1:0] i_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_BUS_W-1:0] o_data,
  output logic [LEVEL_W-1:0]    o_level
);

  generate
    if ((MODE < AXICB_SLICE_BYPASS) || (MODE > AXICB_SLICE_BWD)) begin : g_bad_mode
      $error("axicb_reg_slice: unsupported MODE %0d", MODE);
    end

    if ((MODE == AXICB_SLICE_BYPASS) || (NB_PIPELINE == 0)) begin : g_bypass
      logic w_unused_clk;
      assign w_unused_clk = aclk ^ aresetn ^ srst;
      assign o_valid = i_valid;
      assign o_data  = i_data;
      assign i_ready = o_ready;
      assign o_level = {LEVEL_W{1'b0}};

    end else begin : g_chain
      logic [NB_PIPELINE:0]  w_valid;
      logic [NB_PIPELINE:0]  w_ready;
      logic [DATA_BUS_W-1:0] w_data [NB_PIPELINE+1];
      logic [1:0]            w_cnt  [NB_PIPELINE];
      logic [LEVEL_W-1:0]    w_sum;

      assign w_valid[0]           = i_valid;
      assign w_data[0]            = i_data;
      assign i_ready              = w_ready[0];
      assign o_valid              = w_valid[NB_PIPELINE];
      assign o_data               = w_data[NB_PIPELINE];
      assign w_ready[NB_PIPELINE] = o_ready;

      for (genvar k = 0; k < NB_PIPELINE; k++) begin : g_stage
        axicb_reg_slice_stage #(
          .DATA_BUS_W (DATA_BUS_W),
          .MODE       (MODE)
        ) u_stage (
          .aclk    (aclk),
          .aresetn (aresetn),
          .srst    (srst),
          .i_valid (w_valid[k]),
          .i_ready (w_ready[k]),
          .i_data  (w_data[k]),
          .o_valid (w_valid[k+1]),
          .o_ready (w_ready[k+1]),
          .o_data  (w_data[k+1]),
          .o_count (w_cnt[k])
        );
      end

      // Occupancy is a sum of register-decoded counts, so no port feeds it
      always_comb begin
        w_sum = {LEVEL_W{1'b0}};
        for (int k = 0; k < NB_PIPELINE; k++) begin
          w_sum = w_sum + LEVEL_W'(w_cnt[k]);
        end
      end

      assign o_level = w_sum;
    end
  endgenerate

endmodule

// File: tb/tb_axicb_reg_slice.sv
// Directed bench for axicb_reg_slice: full skid (x2), backward (x1),
// forward (x3) and bypass instances share one clock and reset.
module tb_axicb_reg_slice;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic srst = 1'b0;

  always #5 aclk = ~aclk;

  // f_: MODE 2 x2, b_: MODE 3 x1, d_: MODE 1 x3, p_: MODE 0
  logic       f_i_valid = 1'b0, f_i_ready, f_o_valid, f_o_ready = 1'b0;
  logic [7:0] f_i_data = 8'h00, f_o_data;
  logic [2:0] f_o_level;
  logic       b_i_valid = 1'b0, b_i_ready, b_o_valid, b_o_ready = 1'b0;
  logic [7:0] b_i_data = 8'h00, b_o_data;
  logic [1:0] b_o_level;
  logic       d_i_valid = 1'b0, d_i_ready, d_o_valid, d_o_ready = 1'b0;
  logic [7:0] d_i_data = 8'h00, d_o_data;
  logic [2:0] d_o_level;
  logic       p_i_valid = 1'b0, p_i_ready, p_o_valid, p_o_ready = 1'b0;
  logic [7:0] p_i_data = 8'h00, p_o_data;
  logic [1:0] p_o_level;

  axicb_reg_slice #(.DATA_BUS_W(8), .NB_PIPELINE(2), .MODE(2)) u_full (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(f_i_valid), .i_ready(f_i_ready), .i_data(f_i_data),
    .o_valid(f_o_valid), .o_ready(f_o_ready), .o_data(f_o_data), .o_level(f_o_level));

  axicb_reg_slice #(.DATA_BUS_W(8), .NB_PIPELINE(1), .MODE(3)) u_bwd (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data),
    .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_level(b_o_level));

  axicb_reg_slice #(.DATA_BUS_W(8), .NB_PIPELINE(3), .MODE(1)) u_fwd (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(d_i_valid), .i_ready(d_i_ready), .i_data(d_i_data),
    .o_valid(d_o_valid), .o_ready(d_o_ready), .o_data(d_o_data), .o_level(d_o_level));

  axicb_reg_slice #(.DATA_BUS_W(8), .NB_PIPELINE(1), .MODE(0)) u_byp (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_valid(p_i_valid), .i_ready(p_i_ready), .i_data(p_i_data),
    .o_valid(p_o_valid), .o_ready(p_o_ready), .o_data(p_o_data), .o_level(p_o_level));

  int errors = 0;
  int checks = 0;

  int         f_in_cnt = 0, b_in_cnt = 0, d_in_cnt = 0;
  logic [7:0] f_out_q[$], b_out_q[$], d_out_q[$];

  // Handshakes are recorded half a cycle before the edge that completes them
  always @(negedge aclk) begin
    if (aresetn && !srst) begin
      if (f_i_valid && f_i_ready) f_in_cnt++;
      if (f_o_valid && f_o_ready) f_out_q.push_back(f_o_data);
      if (b_i_valid && b_i_ready) b_in_cnt++;
      if (b_o_valid && b_o_ready) b_out_q.push_back(b_o_data);
      if (d_i_valid && d_i_ready) d_in_cnt++;
      if (d_o_valid && d_o_ready) d_out_q.push_back(d_o_data);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (f_o_valid !== 1'b0) begin errors++; $display("FAIL rst_f_o_valid: got %0b want 0", f_o_valid); end
    checks++; if (f_o_data !== 8'h00) begin errors++; $display("FAIL rst_f_o_data: got %0h want 0", f_o_data); end
    checks++; if (f_o_level !== 3'd0) begin errors++; $display("FAIL rst_f_level: got %0d want 0", f_o_level); end
    checks++; if (f_i_ready !== 1'b0) begin errors++; $display("FAIL rst_f_i_ready: got %0b want 0", f_i_ready); end
    checks++; if (b_i_ready !== 1'b0) begin errors++; $display("FAIL rst_b_i_ready: got %0b want 0", b_i_ready); end
    checks++; if (b_o_valid !== 1'b0) begin errors++; $display("FAIL rst_b_o_valid: got %0b want 0", b_o_valid); end
    checks++; if (d_i_ready !== 1'b1) begin errors++; $display("FAIL rst_d_i_ready: got %0b want 1", d_i_ready); end
    checks++; if (d_o_valid !== 1'b0 || d_o_level !== 3'd0) begin errors++; $display("FAIL rst_d_out: valid %0b level %0d want 0 0", d_o_valid, d_o_level); end
    aresetn = 1'b1;
    #1;
    checks++; if (f_i_ready !== 1'b0) begin errors++; $display("FAIL rel_f_i_ready_pre: got %0b want 0", f_i_ready); end
    tick();
    checks++; if (f_i_ready !== 1'b1) begin errors++; $display("FAIL rel_f_i_ready_post: got %0b want 1", f_i_ready); end
    checks++; if (b_i_ready !== 1'b1) begin errors++; $display("FAIL rel_b_i_ready_post: got %0b want 1", b_i_ready); end
  endtask

  task automatic test_bypass();
    p_i_valid = 1'b1; p_i_data = 8'h5A; p_o_ready = 1'b1;
    #1;
    checks++; if (p_o_valid !== 1'b1 || p_o_data !== 8'h5A) begin errors++; $display("FAIL byp_out: got %0b/%0h want 1/5a", p_o_valid, p_o_data); end
    checks++; if (p_i_ready !== 1'b1 || p_o_level !== 2'd0) begin errors++; $display("FAIL byp_ready_level: got %0b/%0d want 1/0", p_i_ready, p_o_level); end
    p_o_ready = 1'b0;
    #1;
    checks++; if (p_i_ready !== 1'b0) begin errors++; $display("FAIL byp_ready_low: got %0b want 0", p_i_ready); end
    p_i_valid = 1'b0;
  endtask

  task automatic test_full_stream();
    int rdy_err = 0;
    int bad = 0;
    f_out_q.delete();
    f_o_ready = 1'b1; f_i_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      f_i_data = 8'(k);
      if (f_i_ready !== 1'b1) rdy_err++;
      tick();
      if (k == 1) begin
        checks++; if (f_o_valid !== 1'b0) begin errors++; $display("FAIL stream_lat1: o_valid %0b want 0", f_o_valid); end
      end
      if (k == 2) begin
        checks++; if (f_o_valid !== 1'b1 || f_o_data !== 8'h01) begin errors++; $display("FAIL stream_lat2: got %0b/%0h want 1/01", f_o_valid, f_o_data); end
      end
    end
    f_i_valid = 1'b0;
    repeat (2) tick();
    checks++; if (rdy_err != 0) begin errors++; $display("FAIL stream_ready: %0d stalled cycles want 0", rdy_err); end
    checks++; if (f_out_q.size() != 16) begin errors++; $display("FAIL stream_count: got %0d want 16", f_out_q.size()); end
    for (int i = 0; i < f_out_q.size(); i++) if (f_out_q[i] !== 8'(i + 1)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_order: %0d wrong beats want 0", bad); end
    checks++; if (f_o_level !== 3'd0) begin errors++; $display("FAIL stream_level: got %0d want 0", f_o_level); end
  endtask

  task automatic test_full_backpressure();
    int base = f_in_cnt;
    f_out_q.delete();
    f_o_ready = 1'b0; f_i_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      f_i_data = 8'(8'h21 + f_in_cnt - base);
      tick();
    end
    checks++; if (f_in_cnt - base != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", f_in_cnt - base); end
    checks++; if (f_i_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %0b want 0", f_i_ready); end
    checks++; if (f_o_level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d want 4", f_o_level); end
    f_i_valid = 1'b0; f_o_ready = 1'b1;
    tick();
    checks++; if (f_i_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_first_drain: got %0b want 0", f_i_ready); end
    tick();
    checks++; if (f_i_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %0b want 1", f_i_ready); end
    repeat (2) tick();
    checks++; if (f_out_q.size() != 4) begin errors++; $display("FAIL bp_drain_count: got %0d want 4", f_out_q.size()); end
    else begin
      checks++;
      if (f_out_q[0] !== 8'h21 || f_out_q[1] !== 8'h22 || f_out_q[2] !== 8'h23 || f_out_q[3] !== 8'h24) begin
        errors++; $display("FAIL bp_drain_order: got %0h %0h %0h %0h want 21 22 23 24", f_out_q[0], f_out_q[1], f_out_q[2], f_out_q[3]);
      end
    end
    checks++; if (f_o_level !== 3'd0) begin errors++; $display("FAIL bp_level_end: got %0d want 0", f_o_level); end
  endtask

  task automatic test_srst();
    int base = f_in_cnt;
    int guard = 0;
    f_out_q.delete();
    f_o_ready = 1'b0; f_i_valid = 1'b1;
    while ((f_in_cnt - base) < 3 && guard < 20) begin
      f_i_data = 8'(8'h30 + f_in_cnt - base);
      tick();
      guard++;
    end
    checks++; if (f_o_level !== 3'd3) begin errors++; $display("FAIL srst_pre_level: got %0d want 3", f_o_level); end
    srst = 1'b1; f_i_data = 8'h33;
    tick();
    checks++; if (f_o_valid !== 1'b0 || f_o_level !== 3'd0) begin errors++; $display("FAIL srst_clear: valid %0b level %0d want 0 0", f_o_valid, f_o_level); end
    checks++; if (f_i_ready !== 1'b0) begin errors++; $display("FAIL srst_ready: got %0b want 0", f_i_ready); end
    srst = 1'b0; f_i_valid = 1'b0;
    #1;
    checks++; if (f_i_ready !== 1'b0) begin errors++; $display("FAIL srst_ready_hold: got %0b want 0", f_i_ready); end
    tick();
    checks++; if (f_i_ready !== 1'b1) begin errors++; $display("FAIL srst_ready_rise: got %0b want 1", f_i_ready); end
    checks++; if (f_o_valid !== 1'b0 || f_out_q.size() != 0) begin errors++; $display("FAIL srst_no_emit: valid %0b emitted %0d want 0 0", f_o_valid, f_out_q.size()); end
  endtask

  task automatic test_bwd();
    int base;
    int rdy_err = 0;
    int zl_err = 0;
    int bad = 0;
    b_out_q.delete();
    b_o_ready = 1'b1; b_i_valid = 1'b1; b_i_data = 8'h41;
    #1;
    checks++; if (b_o_valid !== 1'b1 || b_o_data !== 8'h41) begin errors++; $display("FAIL bwd_zero_lat: got %0b/%0h want 1/41", b_o_valid, b_o_data); end
    tick();
    b_o_ready = 1'b0; b_i_data = 8'h42;
    tick();
    checks++; if (b_i_ready !== 1'b0 || b_o_level !== 2'd1) begin errors++; $display("FAIL bwd_capture: ready %0b level %0d want 0 1", b_i_ready, b_o_level); end
    b_i_data = 8'h43;
    #1;
    checks++; if (b_o_data !== 8'h42) begin errors++; $display("FAIL bwd_skid_data: got %0h want 42", b_o_data); end
    b_o_ready = 1'b1;
    tick();
    checks++; if (b_i_ready !== 1'b1 || b_o_level !== 2'd0 || b_o_data !== 8'h43) begin errors++; $display("FAIL bwd_drain: ready %0b level %0d data %0h want 1 0 43", b_i_ready, b_o_level, b_o_data); end
    checks++; if (b_out_q.size() != 2 || b_out_q[0] !== 8'h41 || b_out_q[1] !== 8'h42) begin errors++; $display("FAIL bwd_directed_out: %0d beats want 41 42", b_out_q.size()); end
    b_i_valid = 1'b0;
    b_out_q.delete();
    base = b_in_cnt;
    for (int c = 0; c < 60; c++) begin
      b_i_valid = 1'($urandom_range(0, 1));
      b_o_ready = (c % 2 == 0);
      b_i_data  = 8'(8'h60 + b_in_cnt - base);
      #1;
      if (b_i_ready !== (b_o_level == 2'd0)) rdy_err++;
      if (b_o_level == 2'd0 && b_i_valid && (b_o_valid !== 1'b1 || b_o_data !== b_i_data)) zl_err++;
      tick();
    end
    b_i_valid = 1'b0; b_o_ready = 1'b1;
    repeat (3) tick();
    checks++; if (rdy_err != 0) begin errors++; $display("FAIL bwd_ready_vs_skid: %0d cycles wrong want 0", rdy_err); end
    checks++; if (zl_err != 0) begin errors++; $display("FAIL bwd_passthrough: %0d cycles wrong want 0", zl_err); end
    checks++; if (b_out_q.size() != b_in_cnt - base) begin errors++; $display("FAIL bwd_count: out %0d want %0d", b_out_q.size(), b_in_cnt - base); end
    for (int i = 0; i < b_out_q.size(); i++) if (b_out_q[i] !== 8'(8'h60 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bwd_order: %0d wrong beats want 0", bad); end
  endtask

  task automatic test_fwd();
    int base = d_in_cnt;
    int cyc = 0;
    int lvl_err = 0;
    int max_lvl = 0;
    int bad = 0;
    d_out_q.delete();
    while ((d_in_cnt - base) < 10000 && cyc < 60000) begin
      if (int'(d_o_level) != (d_in_cnt - base) - d_out_q.size()) lvl_err++;
      if (int'(d_o_level) > max_lvl) max_lvl = int'(d_o_level);
      d_i_valid = ($urandom_range(0, 3) != 0);
      d_o_ready = ($urandom_range(0, 3) != 0);
      d_i_data  = 8'(d_in_cnt - base);
      tick();
      cyc++;
    end
    d_i_valid = 1'b0; d_o_ready = 1'b1;
    repeat (5) tick();
    checks++; if (d_in_cnt - base != 10000) begin errors++; $display("FAIL fwd_accepted: got %0d want 10000", d_in_cnt - base); end
    checks++; if (d_out_q.size() != 10000) begin errors++; $display("FAIL fwd_emitted: got %0d want 10000", d_out_q.size()); end
    for (int i = 0; i < d_out_q.size(); i++) if (d_out_q[i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL fwd_scoreboard: %0d wrong beats want 0", bad); end
    checks++; if (lvl_err != 0) begin errors++; $display("FAIL fwd_level_track: %0d cycles wrong want 0", lvl_err); end
    checks++; if (max_lvl > 3) begin errors++; $display("FAIL fwd_level_max: got %0d want <=3", max_lvl); end
  endtask

  task automatic test_async_reset();
    int qsize;
    f_out_q.delete();
    f_o_ready = 1'b1; f_i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f_i_data = 8'(8'h70 + k);
      tick();
    end
    b_i_valid = 1'b1; b_o_ready = 1'b0; b_i_data = 8'h7F;
    #2;
    aresetn = 1'b0;
    #1;
    checks++; if (f_o_valid !== 1'b0 || f_o_level !== 3'd0 || f_o_data !== 8'h00) begin errors++; $display("FAIL arst_f_out: valid %0b level %0d data %0h want 0 0 0", f_o_valid, f_o_level, f_o_data); end
    checks++; if (f_i_ready !== 1'b0) begin errors++; $display("FAIL arst_f_ready: got %0b want 0", f_i_ready); end
    checks++; if (b_o_valid !== 1'b0 || b_i_ready !== 1'b0 || b_o_data !== 8'h00) begin errors++; $display("FAIL arst_b_out: valid %0b ready %0b data %0h want 0 0 0", b_o_valid, b_i_ready, b_o_data); end
    f_i_valid = 1'b0; b_i_valid = 1'b0;
    qsize = f_out_q.size();
    tick();
    aresetn = 1'b1;
    repeat (4) tick();
    checks++; if (f_o_valid !== 1'b0 || f_out_q.size() != qsize) begin errors++; $display("FAIL arst_no_output: valid %0b new beats %0d want 0 0", f_o_valid, f_out_q.size() - qsize); end
    f_i_valid = 1'b1; f_i_data = 8'h99;
    tick();
    f_i_valid = 1'b0;
    tick();
    checks++; if (f_o_valid !== 1'b1 || f_o_data !== 8'h99) begin errors++; $display("FAIL arst_new_beat: got %0b/%0h want 1/99", f_o_valid, f_o_data); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_full_stream();
    test_full_backpressure();
    test_srst();
    test_bwd();
    test_fwd();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
